// File: rtl/fir_out_round.sv
// fir_out_round: half-up rounding and saturation of the MAC sum into a show-ahead output FIFO
module fir_out_round #(
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 16,
  parameter int ACC_FRAC    = 30,
  parameter int DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [SAMPLE_SIZE+COEFF_SIZE:0] acc_in,
  input  logic                                  acc_done,
  output logic signed [SAMPLE_SIZE-1:0]         dout,
  output logic                                  dout_sat,
  output logic                                  dout_valid,
  input  logic                                  dout_ready,
  output logic                                  ovf,
  output logic [15:0]                           sat_cnt
);
  localparam int AW = SAMPLE_SIZE + COEFF_SIZE + 1;
  localparam int SH = ACC_FRAC - (SAMPLE_SIZE - 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [AW:0] HALF = (AW+1)'(1) << (SH - 1);
  localparam logic signed [AW:0] MAXV = (AW+1)'(2**(SAMPLE_SIZE-1) - 1);
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic signed [AW:0] ext_w, rnd_w;
  logic               sat_hi, sat_lo, push, pop;
  logic [SAMPLE_SIZE:0] entry_d;
  logic [SAMPLE_SIZE:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        sat_cnt_q, sat_cnt_d;

  // one guard bit keeps the rounding offset from wrapping the most positive sum
  assign ext_w = {acc_in[AW-1], acc_in} + HALF;
  assign rnd_w = ext_w >>> SH;

  always_comb begin
    sat_hi    = rnd_w > MAXV;
    sat_lo    = rnd_w < MINV;
    entry_d   = sat_hi ? {1'b1, 1'b0, {(SAMPLE_SIZE-1){1'b1}}} :
                sat_lo ? {1'b1, 1'b1, {(SAMPLE_SIZE-1){1'b0}}} :
                         {1'b0, rnd_w[SAMPLE_SIZE-1:0]};
    pop       = (cnt_q != '0) && dout_ready;
    push      = acc_done && ((cnt_q != CW'(DEPTH)) || pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    wr_d      = wr_q + PW'(push);
    rd_d      = rd_q + PW'(pop);
    ovf_d     = ovf_q | (acc_done & ~push);
    sat_cnt_d = (push && entry_d[SAMPLE_SIZE] && sat_cnt_q != 16'hFFFF) ? sat_cnt_q + 16'd1 : sat_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= entry_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign {dout_sat, dout} = mem_q[rd_q];
  assign dout_valid = cnt_q != '0;
  assign ovf        = ovf_q;
  assign sat_cnt    = sat_cnt_q;
endmodule

// File: tb/tb_fir_out_round.sv
// tb_fir_out_round: random and directed stimulus checked every cycle against a queue-based model
module tb_fir_out_round;
  localparam int AW = 33;
  localparam int DEPTH = 4;

  logic        clk = 0, rst = 1;
  logic [AW-1:0] acc_in = '0;
  logic        acc_done = 0, dout_ready = 0;
  logic [15:0] dout, sat_cnt;
  logic        dout_sat, dout_valid, ovf;

  fir_out_round dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .acc_done(acc_done),
    .dout(dout), .dout_sat(dout_sat), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .ovf(ovf), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] v; logic s;} ent_t;
  ent_t q[$];
  bit   m_ovf, chk_en, m_pop, m_full;
  int   m_sat;
  int   n_chk = 0, n_err = 0;
  ent_t m_e;
  logic [15:0] last_dout;
  bit   last_stall;

  // Floor((v + 0.5 LSB) / LSB) with LSB = 2^15, then clamp to the Q1.15 range
  function automatic ent_t model(input logic [AW-1:0] a);
    longint v, r;
    ent_t e;
    v = longint'($signed(a)) + 64'sd16384;
    r = (v >= 0) ? v / 32768 : -((-v + 32767) / 32768);
    if (r > 32767) begin e.v = 16'h7FFF; e.s = 1; end
    else if (r < -32768) begin e.v = 16'h8000; e.s = 1; end
    else begin e.v = 16'(r); e.s = 0; end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_sat = 0;
      chk_en = 1;
    end else begin
      m_pop  = q.size() > 0 && dout_ready;
      m_full = q.size() == DEPTH;
      if (m_pop) void'(q.pop_front());
      if (acc_done) begin
        m_e = model(acc_in);
        if (!m_full || m_pop) begin
          q.push_back(m_e);
          if (m_e.s && m_sat < 65535) m_sat++;
        end else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(dout_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("dout", 32'(dout), 32'(q[0].v));
        check("dout_sat", 32'(dout_sat), 32'(q[0].s));
      end
      if (last_stall && dout_valid) check("hold", 32'(dout), 32'(last_dout));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("sat_cnt", 32'(sat_cnt), 32'(m_sat));
      last_stall = dout_valid && !dout_ready && !rst;
      last_dout  = dout;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [AW-1:0] a);
    acc_in = a;
    acc_done = 1;
    tick();
    acc_done = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
  endtask

  logic [AW-1:0] rv [8];
  logic [15:0]   re [8];
  logic          rs [8];
  ent_t          me;
  int            sent, cyc;

  initial begin
    rv = '{33'h0_2000_0000, 33'h4000, 33'h3FFF, -33'sh4000, -33'sh4001,
           33'h0_4000_0000, -33'sh4000_0000, 33'h1_0000_0000};
    re = '{16'h4000, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000};
    rs = '{0, 0, 0, 0, 0, 1, 0, 1};
    last_stall = 0;
    last_dout  = '0;
    tick();
    do_reset();
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_sat", 32'(dout_sat), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_satcnt", 32'(sat_cnt), 0);

    for (int i = 0; i < 8; i++) begin
      me = model(rv[i]);
      check("model_v", 32'(me.v), 32'(re[i]));
      check("model_s", 32'(me.s), 32'(rs[i]));
      dout_ready = 0;
      pulse(rv[i]);
      check("rnd_valid", 32'(dout_valid), 1);
      check("rnd_dout", 32'(dout), 32'(re[i]));
      check("rnd_sat", 32'(dout_sat), 32'(rs[i]));
      dout_ready = 1;
      tick();
      dout_ready = 0;
    end
    check("sat_cnt_2", 32'(sat_cnt), 2);

    for (int i = 1; i <= 5; i++) pulse(AW'(i) << 15);
    check("fill_ovf", 32'(ovf), 1);
    dout_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("fill_valid", 32'(dout_valid), 1);
      check("fill_dout", 32'(dout), 32'(i));
      tick();
    end
    check("fill_empty", 32'(dout_valid), 0);
    dout_ready = 0;

    do_reset();
    for (int i = 1; i <= 4; i++) pulse(AW'(i) << 15);
    acc_in = AW'(6) << 15;
    acc_done = 1;
    dout_ready = 1;
    tick();
    acc_done = 0;
    check("sim_ovf", 32'(ovf), 0);
    check("sim_d2", 32'(dout), 2); tick();
    check("sim_d3", 32'(dout), 3); tick();
    check("sim_d4", 32'(dout), 4); tick();
    check("sim_d6", 32'(dout), 6);
    check("sim_v6", 32'(dout_valid), 1); tick();
    check("sim_empty", 32'(dout_valid), 0);

    check("lat_pre", 32'(dout_valid), 0);
    pulse(33'h8000);
    check("lat_valid", 32'(dout_valid), 1);
    check("lat_dout", 32'(dout), 1);
    tick();
    check("lat_after", 32'(dout_valid), 0);

    sent = 0;
    cyc = 0;
    while (sent < 100 && cyc < 2000) begin
      acc_done = 1'($urandom_range(0, 1));
      acc_in = ($urandom_range(0, 3) == 0) ? {1'($urandom_range(0, 1)), 32'($urandom)}
                                           : AW'($signed(24'($urandom)));
      if (acc_done) sent++;
      dout_ready = $urandom_range(0, 3) != 0;
      tick();
      cyc++;
    end
    acc_done = 0;
    check("rand_sent", 32'(sent), 100);
    dout_ready = 1;
    cyc = 0;
    while (dout_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("drain", 32'(dout_valid), 0);

    do_reset();
    dout_ready = 0;
    pulse(33'h4000);
    for (int i = 0; i < 3; i++) pulse(33'h0_4000_0000);
    pulse(33'h8000);
    dout_ready = 1;
    tick();
    dout_ready = 0;
    check("mid_ovf", 32'(ovf), 1);
    check("mid_satcnt", 32'(sat_cnt), 3);
    check("mid_valid", 32'(dout_valid), 1);
    rst = 1;
    acc_done = 1;
    dout_ready = 1;
    tick();
    rst = 0;
    acc_done = 0;
    dout_ready = 0;
    check("mr_valid", 32'(dout_valid), 0);
    check("mr_dout", 32'(dout), 0);
    check("mr_sat", 32'(dout_sat), 0);
    check("mr_ovf", 32'(ovf), 0);
    check("mr_satcnt", 32'(sat_cnt), 0);
    tick();
    check("mr_still_empty", 32'(dout_valid), 0);
    pulse(33'h4000);
    check("mr_first_valid", 32'(dout_valid), 1);
    check("mr_first_dout", 32'(dout), 1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
